avs_ahb_lite_master: RTL and testbench

- Avalon-MM slave to AHB-Lite master bridge: the reverse direction of the AHB-Lite to Avalon-MM converter.
- Lets Avalon-MM initiators (DMA, debug, soft peripherals) reach the AHB-Lite system bus.
- Single, non-posted transfers, one outstanding at a time. 32-bit data only.
- Sparse byteenable patterns are split into sequential byte transfers.

---
 rtl/avs_ahb_lite_master_if.sv | 49 ++++
 rtl/avs_ahb_lite_master.sv | 188 ++++++++++++++++++
 tb/tb_avs_ahb_lite_master.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avs_ahb_lite_master_if.sv
`default_nettype none
// =============================================================================
// Module   : avs_ahb_lite_master_if
// Brief    : Avalon-MM slave + AHB-Lite master signal bundle for the bridge.
// Revision : 1.0 - initial release
// =============================================================================
interface avs_ahb_lite_master_if #(
  parameter int HADDR_WIDTH = 32,
  parameter int AADDR_WIDTH = 30
);
  logic [AADDR_WIDTH-1:0] avs_address;
  logic                   avs_read;
  logic                   avs_write;
  logic [3:0]             avs_byteenable;
  logic [31:0]            avs_writedata;
  logic [31:0]            avs_readdata;
  logic                   avs_readdatavalid;
  logic                   avs_waitrequest;
  logic [1:0]             avs_response;

  logic [HADDR_WIDTH-1:0] HADDR;
  logic [2:0]             HBURST;
  logic                   HMASTLOCK;
  logic [3:0]             HPROT;
  logic [2:0]             HSIZE;
  logic [1:0]             HTRANS;
  logic                   HWRITE;
  logic [31:0]            HWDATA;
  logic [31:0]            HRDATA;
  logic                   HREADY;
  logic                   HRESP;

  // master: the bridge itself (AHB master, Avalon responder)
  modport master (
    input  avs_address, avs_read, avs_write, avs_byteenable, avs_writedata,
           HRDATA, HREADY, HRESP,
    output avs_readdata, avs_readdatavalid, avs_waitrequest, avs_response,
           HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE, HWDATA
  );

  // slave: the surrounding system (Avalon initiator plus AHB slave)
  modport slave (
    output avs_address, avs_read, avs_write, avs_byteenable, avs_writedata,
           HRDATA, HREADY, HRESP,
    input  avs_readdata, avs_readdatavalid, avs_waitrequest, avs_response,
           HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE, HWDATA
  );
endinterface
`default_nettype wire

// File: rtl/avs_ahb_lite_master.sv
`default_nettype none
// =============================================================================
// Module   : avs_ahb_lite_master
// Brief    : Avalon-MM slave to AHB-Lite master bridge, single non-posted
//            transfers, sparse byteenables split into ascending byte transfers.
// Revision : 1.0 - initial release
// =============================================================================
module avs_ahb_lite_master #(
  parameter int         HADDR_WIDTH = 32,
  parameter int         AADDR_WIDTH = 30,
  parameter int         AADDR_OFFST = 2,
  parameter logic [3:0] HPROT_VAL   = 4'b0011
) (
  input  wire                   HCLK,
  input  wire                   HRESETn,
  avs_ahb_lite_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] c_HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] c_HSIZE_HALF    = 3'd1;
  localparam logic [2:0] c_HSIZE_WORD    = 3'd2;
  localparam logic [1:0] c_RESP_OKAY     = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR   = 2'b10;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [AADDR_WIDTH-1:0] r_addr;
  logic [3:0]             r_be;
  logic [3:0]             r_mask;
  logic [1:0]             r_off;
  logic [2:0]             r_size;
  logic [31:0]            r_wdata;
  logic [31:0]            r_rbuf;
  logic                   r_write;
  logic                   r_err;

  logic                   w_cmd;
  logic                   w_is_read;
  logic                   w_null_write;
  logic [3:0]             w_be_eff;
  logic [2:0]             w_size_dec;
  logic [1:0]             w_off_dec;
  logic [1:0]             w_lane;
  logic [3:0]             w_lane_oh;
  logic [3:0]             w_cur_lanes;
  logic [3:0]             w_mask_left;
  logic [31:0]            w_lane_bits;
  logic                   w_more;
  logic [AADDR_OFFST-1:0] w_off;
  logic [HADDR_WIDTH-1:0] w_haddr;

  logic [1:0]             w_htrans;
  logic                   w_waitreq;
  logic                   w_rdv;
  logic [1:0]             w_resp;

  // Lowest set lane; an empty mask maps to lane 0 so HADDR idles at the base.
  function automatic logic [1:0] f_low_lane(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else if (m[3]) return 2'd3;
    else           return 2'd0;
  endfunction

  assign w_is_read    = bus.avs_read;
  assign w_cmd        = bus.avs_read | bus.avs_write;
  assign w_be_eff     = (w_is_read && (bus.avs_byteenable == 4'b0000)) ? 4'b1111
                                                                       : bus.avs_byteenable;
  assign w_null_write = !w_is_read && (bus.avs_byteenable == 4'b0000);

  always_comb begin
    w_size_dec = c_HSIZE_BYTE;
    w_off_dec  = 2'd0;
    case (w_be_eff)
      4'b1111: w_size_dec = c_HSIZE_WORD;
      4'b0011: w_size_dec = c_HSIZE_HALF;
      4'b1100: begin
        w_size_dec = c_HSIZE_HALF;
        w_off_dec  = 2'd2;
      end
      default: ;
    endcase
  end

  // Byte mode walks r_mask; half/word transfers use the decoded offset.
  assign w_lane      = f_low_lane(r_mask);
  assign w_lane_oh   = 4'b0001 << w_lane;
  assign w_cur_lanes = (r_size == c_HSIZE_BYTE) ? w_lane_oh : r_be;
  assign w_mask_left = r_mask & ~w_lane_oh;
  assign w_more      = (r_size == c_HSIZE_BYTE) && (w_mask_left != 4'b0000);
  assign w_lane_bits = {{8{w_cur_lanes[3]}}, {8{w_cur_lanes[2]}},
                        {8{w_cur_lanes[1]}}, {8{w_cur_lanes[0]}}};
  assign w_off       = AADDR_OFFST'((r_size == c_HSIZE_BYTE) ? w_lane : r_off);
  assign w_haddr     = {r_addr, w_off};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_htrans    = c_HTRANS_IDLE;
    w_waitreq   = 1'b1;
    w_rdv       = 1'b0;
    w_resp      = c_RESP_OKAY;
    case (r_state)
      S_IDLE: begin
        if (w_cmd) w_state_nxt = w_null_write ? S_DONE : S_ADDR;
      end
      S_ADDR: begin
        w_htrans = c_HTRANS_NONSEQ;
        if (bus.HREADY) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (bus.HREADY) w_state_nxt = (w_more && !bus.HRESP) ? S_ADDR : S_DONE;
      end
      S_DONE: begin
        w_waitreq   = 1'b0;
        w_resp      = r_err ? c_RESP_SLVERR : c_RESP_OKAY;
        w_state_nxt = r_write ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        w_rdv       = 1'b1;
        w_resp      = r_err ? c_RESP_SLVERR : c_RESP_OKAY;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr  <= '0;
      r_be    <= '0;
      r_mask  <= '0;
      r_off   <= '0;
      r_size  <= c_HSIZE_BYTE;
      r_wdata <= '0;
      r_rbuf  <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_cmd) begin
        r_addr  <= bus.avs_address;
        r_be    <= w_be_eff;
        r_mask  <= w_be_eff;
        r_off   <= w_off_dec;
        r_size  <= w_size_dec;
        r_wdata <= bus.avs_writedata;
        r_write <= !w_is_read;
        r_err   <= 1'b0;
        r_rbuf  <= '0;
      end else if (r_state == S_DATA && bus.HREADY) begin
        r_rbuf <= (r_rbuf & ~w_lane_bits) | (bus.HRDATA & w_lane_bits);
        r_err  <= r_err | bus.HRESP;
        if (r_size == c_HSIZE_BYTE) r_mask <= w_mask_left;
      end
    end
  end

  assign bus.HADDR             = w_haddr;
  assign bus.HBURST            = 3'b000;
  assign bus.HMASTLOCK         = 1'b0;
  assign bus.HPROT             = HPROT_VAL;
  assign bus.HSIZE             = r_size;
  assign bus.HTRANS            = w_htrans;
  assign bus.HWRITE            = r_write;
  assign bus.HWDATA            = r_wdata;
  assign bus.avs_waitrequest   = w_waitreq;
  assign bus.avs_readdatavalid = w_rdv;
  assign bus.avs_response      = w_resp;
  assign bus.avs_readdata      = w_rdv ? r_rbuf : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_avs_ahb_lite_master.sv
`default_nettype none
// =============================================================================
// Module   : tb_avs_ahb_lite_master
// Brief    : Directed bench with a transaction-level model of the bridge and an
//            AHB slave responder with programmable wait states and errors.
// Revision : 1.0 - initial release
// =============================================================================
module tb_avs_ahb_lite_master;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
  } xfer_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avs_ahb_lite_master_if #(.HADDR_WIDTH(32), .AADDR_WIDTH(30)) bus ();

  avs_ahb_lite_master #(
    .HADDR_WIDTH(32), .AADDR_WIDTH(30), .AADDR_OFFST(2), .HPROT_VAL(4'b0011)
  ) dut (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus)
  );

  // slave configuration for the current command
  int          cfg_wait;
  int          cfg_err_beat;
  logic [31:0] cfg_rdata;

  // model state
  xfer_t       exp_q[$];
  bit          m_busy, m_write, acc_now, rdv_now, acc_nxt, dp_active;
  logic [31:0] m_wdata, m_rdata, dp_lanes;
  logic [1:0]  m_resp;

  // observations of the DUT for literal checks
  int          mon_n, mon_acc_cnt, mon_rdv_cnt, mon_acc_cyc, mon_rdv_cyc, start_cyc;
  logic [31:0] mon_haddr[8];
  logic [2:0]  mon_hsize[8];
  logic [1:0]  mon_acc_resp, mon_rdv_resp;
  logic [31:0] mon_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes_of(input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] m;
    if (sz == 3'd2)      m = 32'hFFFF_FFFF;
    else if (sz == 3'd1) m = 32'h0000_FFFF << (8 * a[1:0]);
    else                 m = 32'h0000_00FF << (8 * a[1:0]);
    return m;
  endfunction

  function automatic void push_x(input logic [31:0] a, input logic [2:0] sz);
    xfer_t x;
    x.addr = a;
    x.size = sz;
    exp_q.push_back(x);
  endfunction

  // Expected AHB transfer list of one Avalon command.
  function automatic void build(input logic [29:0] wa, input logic [3:0] be, input bit rd);
    logic [3:0]  b;
    logic [31:0] base;
    b    = (rd && be == 4'h0) ? 4'hF : be;
    base = {wa, 2'b00};
    exp_q.delete();
    if (b == 4'hF)      push_x(base, 3'd2);
    else if (b == 4'h3) push_x(base, 3'd1);
    else if (b == 4'hC) push_x(base + 32'd2, 3'd1);
    else for (int i = 0; i < 4; i++) if (b[i]) push_x(base + 32'(i), 3'd0);
  endfunction

  // AHB slave: one data phase per accepted NONSEQ.
  bit sl_start, sl_busy, sl_err, sl_errfirst;
  int sl_wait, sl_beat;
  initial begin
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = 32'h0;
    sl_busy    = 1'b0;
    sl_beat    = 0;
    forever begin
      @(negedge clk);
      sl_start = rst_n && bus.HTRANS == 2'b10 && bus.HREADY;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        sl_busy = 1'b0;
      end else if (sl_start) begin
        sl_busy     = 1'b1;
        sl_wait     = cfg_wait;
        sl_err      = (sl_beat == cfg_err_beat);
        sl_errfirst = 1'b0;
        sl_beat++;
      end
      if (!sl_busy) begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
      end else if (sl_wait > 0) begin
        bus.HREADY = 1'b0; bus.HRESP = 1'b0; sl_wait--;
      end else if (sl_err && !sl_errfirst) begin
        bus.HREADY = 1'b0; bus.HRESP = 1'b1; sl_errfirst = 1'b1;
      end else begin
        bus.HREADY = 1'b1; bus.HRESP = sl_err; bus.HRDATA = cfg_rdata; sl_busy = 1'b0;
      end
    end
  end

  // Compare process: every cycle, DUT outputs against the transaction model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_htrans", 32'(bus.HTRANS), 32'h0);
      chk("rst_waitrequest", 32'(bus.avs_waitrequest), 32'h1);
      chk("rst_readdatavalid", 32'(bus.avs_readdatavalid), 32'h0);
      chk("rst_response", 32'(bus.avs_response), 32'h0);
      chk("rst_readdata", bus.avs_readdata, 32'h0);
      chk("rst_haddr", bus.HADDR, 32'h0);
      chk("rst_hsize", 32'(bus.HSIZE), 32'h0);
      chk("rst_hwrite", 32'(bus.HWRITE), 32'h0);
      chk("rst_hwdata", bus.HWDATA, 32'h0);
      m_busy = 0; acc_now = 0; rdv_now = 0; dp_active = 0;
      exp_q.delete();
    end else begin
      chk("hburst", 32'(bus.HBURST), 32'h0);
      chk("hmastlock", 32'(bus.HMASTLOCK), 32'h0);
      chk("hprot", 32'(bus.HPROT), 32'h3);
      chk("waitrequest", 32'(bus.avs_waitrequest), 32'(!acc_now));
      if (acc_now) chk("accept_response", 32'(bus.avs_response), 32'(m_resp));
      chk("readdatavalid", 32'(bus.avs_readdatavalid), 32'(rdv_now));
      if (rdv_now) begin
        chk("readdata", bus.avs_readdata, m_rdata);
        chk("read_response", 32'(bus.avs_response), 32'(m_resp));
      end
      if (!bus.avs_waitrequest) begin
        mon_acc_cnt++; mon_acc_cyc = cyc; mon_acc_resp = bus.avs_response;
      end
      if (bus.avs_readdatavalid) begin
        mon_rdv_cnt++; mon_rdv_cyc = cyc; mon_rdata = bus.avs_readdata;
        mon_rdv_resp = bus.avs_response;
      end

      acc_nxt = 1'b0;
      if (!m_busy && (bus.avs_read || bus.avs_write)) begin
        m_busy  = 1'b1;
        m_write = !bus.avs_read;
        m_wdata = bus.avs_writedata;
        m_rdata = 32'h0;
        m_resp  = 2'b00;
        build(bus.avs_address, bus.avs_byteenable, bus.avs_read);
        if (exp_q.size() == 0) acc_nxt = 1'b1;
      end

      if (dp_active) begin
        chk("htrans_in_data_phase", 32'(bus.HTRANS), 32'h0);
        if (bus.HREADY) begin
          if (m_write) chk("hwdata", bus.HWDATA, m_wdata);
          m_rdata = m_rdata | (cfg_rdata & dp_lanes);
          if (bus.HRESP) begin
            m_resp = 2'b10;
            exp_q.delete();
          end
          dp_active = 1'b0;
          if (exp_q.size() == 0) acc_nxt = 1'b1;
        end
      end else if (bus.HTRANS != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_htrans", 32'(bus.HTRANS), 32'h0);
        end else begin
          chk("htrans_nonseq", 32'(bus.HTRANS), 32'h2);
          chk("haddr", bus.HADDR, exp_q[0].addr);
          chk("hsize", 32'(bus.HSIZE), 32'(exp_q[0].size));
          chk("hwrite", 32'(bus.HWRITE), 32'(m_write));
          if (bus.HREADY) begin
            if (mon_n < 8) begin
              mon_haddr[mon_n] = bus.HADDR;
              mon_hsize[mon_n] = bus.HSIZE;
            end
            mon_n++;
            dp_lanes  = lanes_of(exp_q[0].addr, exp_q[0].size);
            dp_active = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end

      if ((acc_now && m_write) || rdv_now) m_busy = 1'b0;
      rdv_now = acc_now && !m_write;
      acc_now = acc_nxt;
    end
  end

  task automatic clr_mon();
    mon_n = 0; mon_acc_cnt = 0; mon_rdv_cnt = 0; mon_acc_cyc = -1; mon_rdv_cyc = -1;
  endtask

  task automatic do_cmd(input bit wr, input logic [29:0] wa, input logic [3:0] be,
                        input logic [31:0] wd, input int wt, input int eb,
                        input logic [31:0] rd);
    int k;
    @(posedge clk);
    #1;
    cfg_wait = wt; cfg_err_beat = eb; cfg_rdata = rd; sl_beat = 0;
    clr_mon();
    bus.avs_address    = wa;
    bus.avs_byteenable = be;
    bus.avs_writedata  = wd;
    bus.avs_write      = wr;
    bus.avs_read       = !wr;
    start_cyc          = cyc;
    k = 0;
    do begin @(negedge clk); k++; end while (bus.avs_waitrequest && k < 40);
    if (bus.avs_waitrequest) chk("accept_timeout", 32'(bus.avs_waitrequest), 32'h0);
    @(posedge clk);
    #1;
    bus.avs_read  = 1'b0;
    bus.avs_write = 1'b0;
    if (!wr) begin
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.avs_readdatavalid && k < 40);
      if (!bus.avs_readdatavalid) chk("rdv_timeout", 32'(bus.avs_readdatavalid), 32'h1);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    bus.avs_byteenable = 4'h0; bus.avs_writedata = 32'h0;
    cfg_wait = 0; cfg_err_beat = -1; cfg_rdata = 32'h0;
    clr_mon();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // full-word write, zero-wait
    do_cmd(1'b1, 30'h100, 4'hF, 32'hDEADBEEF, 0, -1, 32'h0);
    chk("t1_nxfer", 32'(mon_n), 32'd1);
    chk("t1_haddr", mon_haddr[0], 32'h400);
    chk("t1_hsize", 32'(mon_hsize[0]), 32'd2);
    chk("t1_latency", 32'(mon_acc_cyc - start_cyc), 32'd3);
    chk("t1_resp", 32'(mon_acc_resp), 32'h0);

    // upper-half read
    do_cmd(1'b0, 30'h10, 4'hC, 32'h0, 0, -1, 32'hAABBCCDD);
    chk("t2_haddr", mon_haddr[0], 32'h42);
    chk("t2_hsize", 32'(mon_hsize[0]), 32'd1);
    chk("t2_rdata", mon_rdata, 32'hAABB0000);
    chk("t2_rdv_after_accept", 32'(mon_rdv_cyc - mon_acc_cyc), 32'd1);

    // sparse write split into two bytes
    do_cmd(1'b1, 30'h20, 4'b0101, 32'h11223344, 0, -1, 32'h0);
    chk("t3_nxfer", 32'(mon_n), 32'd2);
    chk("t3_haddr0", mon_haddr[0], 32'h80);
    chk("t3_haddr1", mon_haddr[1], 32'h82);
    chk("t3_hsize0", 32'(mon_hsize[0]), 32'd0);
    chk("t3_hsize1", 32'(mon_hsize[1]), 32'd0);
    chk("t3_accepts", 32'(mon_acc_cnt), 32'd1);

    // word read with three wait states
    do_cmd(1'b0, 30'h33, 4'hF, 32'h0, 3, -1, 32'h12345678);
    chk("t4_haddr", mon_haddr[0], 32'hCC);
    chk("t4_rdata", mon_rdata, 32'h12345678);
    chk("t4_latency", 32'(mon_acc_cyc - start_cyc), 32'd6);

    // split write aborted by an error on the first byte
    do_cmd(1'b1, 30'h40, 4'b0111, 32'hA1B2C3D4, 0, 0, 32'h0);
    chk("t5_nxfer", 32'(mon_n), 32'd1);
    chk("t5_haddr", mon_haddr[0], 32'h100);
    chk("t5_resp", 32'(mon_acc_resp), 32'h2);
    chk("t5_latency", 32'(mon_acc_cyc - start_cyc), 32'd4);

    // reset during the data phase of a read
    @(posedge clk);
    #1;
    cfg_wait = 3; cfg_err_beat = -1; cfg_rdata = 32'hCAFEF00D; sl_beat = 0;
    clr_mon();
    bus.avs_address = 30'h7; bus.avs_byteenable = 4'hF; bus.avs_read = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!(bus.HTRANS == 2'b10 && bus.HREADY) && k < 20);
    if (bus.HTRANS != 2'b10) chk("t6_nonseq_timeout", 32'(bus.HTRANS), 32'h2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_htrans_now", 32'(bus.HTRANS), 32'h0);
    chk("t6_wait_now", 32'(bus.avs_waitrequest), 32'h1);
    bus.avs_read = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    chk("t6_no_rdv", 32'(mon_rdv_cnt), 32'd0);
    do_cmd(1'b0, 30'h8, 4'hF, 32'h0, 0, -1, 32'h0BADF00D);
    chk("t6_after_rdata", mon_rdata, 32'h0BADF00D);
    chk("t6_after_haddr", mon_haddr[0], 32'h20);

    // write with no lanes: no AHB transfer
    do_cmd(1'b1, 30'h9, 4'h0, 32'h55555555, 0, -1, 32'h0);
    chk("t7_nxfer", 32'(mon_n), 32'd0);
    chk("t7_latency", 32'(mon_acc_cyc - start_cyc), 32'd1);
    chk("t7_resp", 32'(mon_acc_resp), 32'h0);

    // read with no lanes behaves as a word read
    do_cmd(1'b0, 30'hA, 4'h0, 32'h0, 0, -1, 32'h87654321);
    chk("t8_hsize", 32'(mon_hsize[0]), 32'd2);
    chk("t8_rdata", mon_rdata, 32'h87654321);

    // sparse read: lanes 0 and 3
    do_cmd(1'b0, 30'h5, 4'b1001, 32'h0, 1, -1, 32'hAABBCCDD);
    chk("t9_nxfer", 32'(mon_n), 32'd2);
    chk("t9_haddr1", mon_haddr[1], 32'h17);
    chk("t9_rdata", mon_rdata, 32'hAA0000DD);

    // one-hot byte read at lane 2
    do_cmd(1'b0, 30'h3, 4'b0100, 32'h0, 0, -1, 32'h11223344);
    chk("t10_haddr", mon_haddr[0], 32'h0E);
    chk("t10_hsize", 32'(mon_hsize[0]), 32'd0);
    chk("t10_rdata", mon_rdata, 32'h00220000);
    chk("t10_resp", 32'(mon_rdv_resp), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
